// File: rtl/leb128_encoder.sv
// leb128_encoder
//   Encodes one WIDTH-bit integer per transaction into a LEB128 byte stream,
//   unsigned (ULEB128) or signed (SLEB128) as selected per word. The word is
//   latched into a shift register and emitted 7 bits at a time, least
//   significant group first, one byte per output handshake.
//
// Ports
//   clk        clock
//   reset      synchronous active-low reset
//   in_data    integer to encode
//   in_signed  1 = SLEB128, 0 = ULEB128; sampled together with in_data
//   in_valid   producer has a word
//   in_ready   encoder can accept a word (IDLE only)
//   out_byte   current encoded byte {continuation, 7 data bits}
//   out_valid  out_byte is valid
//   out_last   current byte is the final byte of the word
//   out_index  0-based position of the current byte within the word
//   out_ready  consumer accepts out_byte

module leb128_encoder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    output logic             out_last,
    output logic [3:0]       out_index,
    input  logic             out_ready
);

    // Maximum number of bytes a WIDTH-bit word can need.
    localparam int unsigned MAXB     = (WIDTH + 6) / 7;
    localparam logic [3:0]  LAST_IDX = 4'(MAXB - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             sgn;
    logic [3:0]       idx_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [6:0]       low7;
    logic [WIDTH-1:0] nxt;
    logic             done;

    // Byte formation from the current shift-register contents.
    always_comb begin
        low7 = sr[6:0];
        // Arithmetic shift for signed words, logical for unsigned.
        nxt  = {{7{sgn & sr[WIDTH-1]}}, sr[WIDTH-1:7]};
        if (sgn) begin
            done = ((nxt == '0) && !low7[6]) || ((nxt == '1) && low7[6]);
        end else begin
            done = (nxt == '0);
        end
        // The rule always terminates by the last possible byte; the index
        // term only bounds out_index and never changes the encoding.
        if (idx_q == LAST_IDX) begin
            done = 1'b1;
        end
    end

    // State, shift register and handshake flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sr          <= '0;
            sgn         <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sr          <= in_data;
                        sgn         <= in_signed;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_valid_q && out_ready) begin
                        if (done) begin
                            // Word finished: one idle bubble before the
                            // next word can be accepted.
                            idx_q       <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            sr    <= nxt;
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte/last are gated so that they read zero whenever nothing is offered.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_valid_q ? {~done, low7} : 8'h00;
    assign out_last  = out_valid_q & done;
    assign out_index = idx_q;

endmodule

// File: tb/tb_leb128_encoder.sv
module tb_leb128_encoder;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic        in_signed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic [3:0]  out_index;
    logic        out_ready;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q[$];

    leb128_encoder #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_index (out_index),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Minimal number of bits needed to represent v (two's complement incl.
    // sign bit when signed).
    function automatic int sig_bits(input logic [63:0] v, input logic s);
        logic [63:0] m;
        int n;
        n = 1;
        if (!s) begin
            for (int i = 0; i < 64; i++) if (v[i]) n = i + 1;
        end else begin
            m = v[63] ? ~v : v;
            for (int i = 0; i < 64; i++) if (m[i]) n = i + 2;
        end
        return n;
    endfunction

    // Reference byte sequence: extend the value to 70 bits and slice into
    // ceil(bits/7) groups of 7, continuation set on all but the last.
    task automatic build_expected(input logic [63:0] v, input logic s);
        logic [69:0] ext;
        int nb;
        ext = {{6{s & v[63]}}, v};
        nb  = (sig_bits(v, s) + 6) / 7;
        exp_q.delete();
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back({(i != nb - 1) ? 1'b1 : 1'b0, ext[7*i +: 7]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send one word and check every byte. stall_idx/stall_n hold out_ready low
    // (pulsing in_valid) while that byte is offered; rnd adds random stalls.
    task automatic send_word(input logic [63:0] v, input logic s,
                             input int stall_idx, input int stall_n, input bit rnd);
        int t;
        int k;
        build_expected(v, s);
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_data   = v;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_data   = ~v;
        in_signed = ~s;
        for (int i = 0; i < exp_q.size(); i++) begin
            k = (i == stall_idx) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int j = 0; j <= k; j++) begin
                out_ready = (j == k);
                in_valid  = (j < k) && (i == stall_idx);
                check("out_valid", {63'd0, out_valid}, 64'd1);
                check("out_byte", {56'd0, out_byte}, {56'd0, exp_q[i]});
                check("out_last", {63'd0, out_last}, {63'd0, (i == exp_q.size() - 1)});
                check("out_index", {60'd0, out_index}, 64'(i));
                check("in_ready_busy", {63'd0, in_ready}, 64'd0);
                tick();
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        check("bubble_in_ready", {63'd0, in_ready}, 64'd1);
        check("bubble_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        reset     = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_out_byte", {56'd0, out_byte}, 64'd0);
        check("rst_out_index", {60'd0, out_index}, 64'd0);
        reset = 1'b1;
        tick();

        // Spot checks of the reference model against known encodings.
        build_expected(64'd624485, 1'b0);
        check("ref_uleb_len", 64'(exp_q.size()), 64'd3);
        check("ref_uleb_b0", {56'd0, exp_q[0]}, 64'hE5);
        build_expected(-64'sd123456, 1'b1);
        check("ref_sleb_b2", {56'd0, exp_q[2]}, 64'h78);

        send_word(64'd0, 1'b0, -1, 0, 1'b0);
        send_word(64'd624485, 1'b0, -1, 0, 1'b0);
        send_word(-64'sd123456, 1'b1, -1, 0, 1'b0);
        send_word(-64'sd1, 1'b1, -1, 0, 1'b0);
        send_word(64'd64, 1'b1, -1, 0, 1'b0);
        send_word(-64'sd64, 1'b1, -1, 0, 1'b0);
        send_word(64'd63, 1'b1, -1, 0, 1'b0);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 0, 1'b0);
        send_word(64'h8000_0000_0000_0000, 1'b1, -1, 0, 1'b0);
        send_word(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, -1, 0, 1'b0);

        // Backpressure on byte 1 with in_valid pulsed mid-stream.
        send_word(64'd624485, 1'b0, 1, 3, 1'b0);

        // Reset while byte 1 of a 3-byte word is offered.
        in_data   = 64'd624485;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_b0", {56'd0, out_byte}, 64'hE5);
        tick();
        check("rst_mid_b1", {56'd0, out_byte}, 64'h8E);
        reset = 1'b0;
        tick();
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_quiet", {63'd0, out_valid}, 64'd0);
        send_word(64'd5, 1'b0, -1, 0, 1'b0);

        // Randomized words of varied magnitude and signedness.
        for (int n = 0; n < 60; n++) begin
            v = {$urandom, $urandom};
            v = v >> $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0) v = ~v;
            send_word(v, 1'($urandom_range(0, 1)), -1, 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
